// File: rtl/stride_counter_bank.sv
// stride_counter_bank: NUM_CH independent counters. Each one adds its own
// programmable stride on every enabled cycle, and each channel is set to
// either wrap or saturate when it overflows. The block also has direct
// load, overflow signalling and a registered one-channel readback port.
//
// Strobe semantics: cfg_valid, load_valid and rd_req are single-cycle
// valid-only strobes. There is no ready: each strobe is accepted in the
// cycle it is high. rd_valid answers every rd_req exactly one cycle later
// and lasts one cycle. reset is synchronous and wins over every strobe.
module stride_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    cfg_valid,
    input  logic [3:0]              cfg_ch,
    input  logic [STEP_W-1:0]       cfg_step,
    input  logic                    cfg_sat,
    input  logic                    load_valid,
    input  logic [3:0]              load_ch,
    input  logic [WIDTH-1:0]        load_value,
    input  logic                    rd_req,
    input  logic [3:0]              rd_ch,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       wrap_pulse,
    output logic [NUM_CH-1:0]       sat_flag,
    output logic                    rd_valid,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0]  cnt_q      [NUM_CH];
    logic [STEP_W-1:0] step_q     [NUM_CH];
    logic [NUM_CH-1:0] sat_mode_q;
    logic [WIDTH:0]    sum        [NUM_CH];
    logic [WIDTH-1:0]  rd_mux;

    // The candidate next value is one bit wider than the counter.
    // Its top bit is the carry, which tells the increment logic that the
    // counter overflowed.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, cnt_q[i]} + {{(WIDTH + 1 - STEP_W){1'b0}}, step_q[i]};
        end
    end

    // Packs all counters onto the flat count bus, with channel i in
    // count[i*WIDTH +: WIDTH].
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count[i*WIDTH +: WIDTH] = cnt_q[i];
        end
    end

    // Readback selection. A channel number that does not exist selects
    // nothing, so it reads as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == 4'(i)) begin
                rd_mux = cnt_q[i];
            end
        end
    end

    // Per-channel state. On a channel, load wins over increment. A config
    // write changes the stride and mode used from the next cycle onward,
    // so an increment in the same cycle still uses the old settings.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                step_q[i]     <= STEP_W'(i + 1);
                sat_mode_q[i] <= 1'b0;
                sat_flag[i]   <= 1'b0;
                wrap_pulse[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wrap_pulse[i] <= 1'b0;
                if (load_valid && (load_ch == 4'(i))) begin
                    cnt_q[i]    <= load_value;
                    sat_flag[i] <= 1'b0;
                end else if (en[i] && (step_q[i] != '0)) begin
                    if (sum[i][WIDTH]) begin
                        if (sat_mode_q[i]) begin
                            cnt_q[i]    <= '1;
                            sat_flag[i] <= 1'b1;
                        end else begin
                            cnt_q[i]      <= sum[i][WIDTH-1:0];
                            wrap_pulse[i] <= 1'b1;
                        end
                    end else begin
                        cnt_q[i] <= sum[i][WIDTH-1:0];
                    end
                end
                if (cfg_valid && (cfg_ch == 4'(i))) begin
                    step_q[i]     <= cfg_step;
                    sat_mode_q[i] <= cfg_sat;
                end
            end
        end
    end

    // Registered readback. It returns the value the counter showed in the
    // request cycle. A request made during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            rd_data  <= rd_req ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_stride_counter_bank.sv
// Directed bench for stride_counter_bank (NUM_CH=4, WIDTH=8, STEP_W=4).
// A vector table steps through counting, wrap, saturate, collision and
// ignored-index cases. Hand-written sequences then cover back-to-back
// readback and a reset that arrives while strobes are active.
module tb_stride_counter_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic                    clk;
    logic                    reset;
    logic [NUM_CH-1:0]       en;
    logic                    cfg_valid;
    logic [3:0]              cfg_ch;
    logic [STEP_W-1:0]       cfg_step;
    logic                    cfg_sat;
    logic                    load_valid;
    logic [3:0]              load_ch;
    logic [WIDTH-1:0]        load_value;
    logic                    rd_req;
    logic [3:0]              rd_ch;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       wrap_pulse;
    logic [NUM_CH-1:0]       sat_flag;
    logic                    rd_valid;
    logic [WIDTH-1:0]        rd_data;

    stride_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk(clk), .reset(reset), .en(en),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_step(cfg_step), .cfg_sat(cfg_sat),
        .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
        .rd_req(rd_req), .rd_ch(rd_ch),
        .count(count), .wrap_pulse(wrap_pulse), .sat_flag(sat_flag),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic        cv;
        logic [3:0]  cc;
        logic [3:0]  cs;
        logic        csat;
        logic        lv;
        logic [3:0]  lc;
        logic [7:0]  lval;
        logic [31:0] ecount;
        logic [3:0]  ewrap;
        logic [3:0]  esat;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] exp_q[$];
    int               n_vec = 0;
    int               n_bad = 0;
    int               n_rd  = 0;

    function automatic vec_t mk(logic rst, logic [3:0] e, logic cv, logic [3:0] cc,
                                logic [3:0] cs, logic csat, logic lv, logic [3:0] lc,
                                logic [7:0] lval, logic [31:0] ec, logic [3:0] ew,
                                logic [3:0] es);
        vec_t v;
        v.rst = rst; v.en = e; v.cv = cv; v.cc = cc; v.cs = cs; v.csat = csat;
        v.lv = lv; v.lc = lc; v.lval = lval; v.ecount = ec; v.ewrap = ew; v.esat = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: puts every input in the idle state.
    task automatic drive_idle();
        reset = 1'b0; en = '0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_step = '0; cfg_sat = 1'b0;
        load_valid = 1'b0; load_ch = '0; load_value = '0;
        rd_req = 1'b0; rd_ch = '0;
    endtask

    // Driver: advances to just after the next rising edge, where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rd_valid must match the oldest expected readback value.
    task automatic sb_sample(input string name);
        if (rd_valid === 1'b1) begin
            n_rd++;
            if (exp_q.size() == 0) begin
                check({name, "_unexpected_rd_valid"}, 32'd1, 32'd0);
            end else begin
                check(name, 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;

        //         rst en    cv cc  cs  ct  lv lc  lval   count          wrap  sat
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h00000000, 4'h0, 4'h0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h00000000, 4'h0, 4'h0));
        // count with the reset strides 1,2,3,4
        vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 8'h00, 32'h04030201, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 8'h00, 32'h08060402, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0C090603, 4'h0, 4'h0));
        // wrap on ch1: 254 -> 0 (pulse) -> 2
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 1, 8'hFE, 32'h0C09FE03, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'h2, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0C090003, 4'h2, 4'h0));
        vecs.push_back(mk(0, 4'h2, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0C090203, 4'h0, 4'h0));
        // saturate on ch2: step 5, load 250 -> 255, 255 (flag), sticky, load clears
        vecs.push_back(mk(0, 4'h0, 1, 2, 5, 1, 1, 2, 8'hFA, 32'h0CFA0203, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0CFF0203, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0CFF0203, 4'h0, 4'h4));
        vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0CFF0203, 4'h0, 4'h4));
        vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0, 1, 2, 8'h07, 32'h0C070203, 4'h0, 4'h0));
        // load beats increment; cfg in the same cycle as increment uses the old step
        vecs.push_back(mk(0, 4'h1, 0, 0, 0, 0, 1, 0, 8'h64, 32'h0C070264, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'h1, 1, 0, 9, 0, 0, 0, 8'h00, 32'h0C070265, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'h1, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0C07026E, 4'h0, 4'h0));
        // out-of-range cfg/load channels are ignored
        vecs.push_back(mk(0, 4'h0, 1, 5, 0, 1, 1, 7, 8'h33, 32'h0C07026E, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 8'h00, 32'h100C0477, 4'h0, 4'h0));
        // step 0 on ch3: holds, no pulse
        vecs.push_back(mk(0, 4'h0, 1, 3, 0, 0, 0, 0, 8'h00, 32'h100C0477, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 0, 0, 0, 0, 8'h00, 32'h100C0477, 4'h0, 4'h0));

        foreach (vecs[k]) begin
            reset = vecs[k].rst; en = vecs[k].en;
            cfg_valid = vecs[k].cv; cfg_ch = vecs[k].cc; cfg_step = vecs[k].cs;
            cfg_sat = vecs[k].csat;
            load_valid = vecs[k].lv; load_ch = vecs[k].lc; load_value = vecs[k].lval;
            rd_req = 1'b0; rd_ch = '0;
            tick();
            check($sformatf("v%0d_count", k), count, vecs[k].ecount);
            check($sformatf("v%0d_wrap", k), 32'(wrap_pulse), 32'(vecs[k].ewrap));
            check($sformatf("v%0d_sat", k), 32'(sat_flag), 32'(vecs[k].esat));
            check($sformatf("v%0d_rd_valid", k), 32'(rd_valid), 32'd0);
            if (k == 0) check("v0_rd_data", 32'(rd_data), 32'd0);
        end

        // Back-to-back readback while counting. Values are those visible
        // in each request cycle: ch0 step 9, ch1 step 2, ch2 step 5, ch3 step 0.
        drive_idle();
        en = 4'hF;
        rd_req = 1'b1;
        rd_ch = 4'd0; exp_q.push_back(8'h77); tick(); sb_sample("rd_ch0");
        rd_ch = 4'd1; exp_q.push_back(8'h06); tick(); sb_sample("rd_ch1");
        rd_ch = 4'd2; exp_q.push_back(8'h16); tick(); sb_sample("rd_ch2");
        rd_ch = 4'd3; exp_q.push_back(8'h10); tick(); sb_sample("rd_ch3");
        en = 4'h0;
        rd_ch = 4'd15; exp_q.push_back(8'h00); tick(); sb_sample("rd_ch15");
        check("rd_count", count, 32'h10200C9B);
        rd_req = 1'b0;
        tick(); sb_sample("rd_tail");
        check("rd_valid_drop", 32'(rd_valid), 32'd0);
        check("rd_total", 32'(n_rd), 32'd5);
        check("rd_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with every strobe active
        en = 4'hF; reset = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_step = 4'hF; cfg_sat = 1'b1;
        load_valid = 1'b1; load_ch = 4'd0; load_value = 8'h55;
        rd_req = 1'b1; rd_ch = 4'd0;
        tick();
        check("rst_count", count, 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        check("rst_wrap", 32'(wrap_pulse), 32'd0);
        drive_idle();
        en = 4'hF;
        tick();
        check("rst_strides", count, 32'h04030201);
        check("rst_rd_idle", 32'(rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
